// File: rtl/spi_master_ctrl_if.sv
// Command/response handshake and SPI pins of spi_master_ctrl.
// frame_cnt exists only when SPI_MASTER_FRAME_CNT_EN is defined.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    input  cmd_valid, cmd_op, cmd_data, MISO,
    output cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
`ifdef SPI_MASTER_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, MISO,
    input  cmd_ready, rsp_valid, rsp_data, busy, SS_n, MOSI
`ifdef SPI_MASTER_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI master: turns one {op,data} command into one SPI frame, returns the read byte for rd-data.
// Optional completed-frame counter enabled by SPI_MASTER_FRAME_CNT_EN.
module spi_master_ctrl #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned IDLE_GAP   = 1
) (
  input logic              clk,
  input logic              rst_n,
  spi_master_ctrl_if.master bus
);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FRAME_W = OP_W + DATA_W;
  localparam int unsigned CNT_W   = 4;

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TURNAROUND - 1);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);
  localparam logic [OP_W-1:0]  OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_SHIFT, ST_WAIT, ST_READ, ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               rd_q, rd_d;
`ifdef SPI_MASTER_FRAME_CNT_EN
  logic [15:0]        frame_cnt_q, frame_cnt_d;
`endif

  // Next-state and output decode; MOSI defaults low outside START/SHIFT.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    ss_n_d      = ss_n_q;
    mosi_d      = 1'b0;
    rd_d        = rd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = ST_START;
          shift_d = {bus.cmd_op, bus.cmd_data};
          rd_d    = (bus.cmd_op == OP_RD_DATA);
          ss_n_d  = 1'b0;
          mosi_d  = bus.cmd_op[1];
          cnt_d   = '0;
        end
      end
      ST_START: begin
        state_d = ST_SHIFT;
        mosi_d  = shift_q[FRAME_W-1];
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (rd_q) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_GAP;
            ss_n_d  = 1'b1;
          end
        end else begin
          mosi_d  = shift_q[FRAME_W-1];
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_READ: begin
        rx_d = {rx_q[DATA_W-2:0], bus.MISO};
        if (cnt_q == READ_LAST) begin
          state_d     = ST_GAP;
          ss_n_d      = 1'b1;
          rsp_data_d  = {rx_q[DATA_W-2:0], bus.MISO};
          rsp_valid_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ss_n_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
`ifdef SPI_MASTER_FRAME_CNT_EN
    // SS_n only rises at a normal frame end; reset-aborted frames bypass this path.
    frame_cnt_d = frame_cnt_q;
    if (ss_n_d && !ss_n_q) frame_cnt_d = frame_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_q        <= 1'b0;
`ifdef SPI_MASTER_FRAME_CNT_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      rd_q        <= rd_d;
`ifdef SPI_MASTER_FRAME_CNT_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // Ready drops combinationally with rst_n so nothing is accepted during reset.
  assign bus.cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
`ifdef SPI_MASTER_FRAME_CNT_EN
  assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: an SPI slave + RAM model on the pins and a command-level reference model.
module tb_spi_master_ctrl;
  localparam int unsigned TA  = 2;
  localparam int unsigned GAP = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_ctrl_if bus_if ();

  spi_master_ctrl #(.TURNAROUND(TA), .IDLE_GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int          len;
    logic [10:0] bits;
    int          gap;
    int          rcnt;
    logic [7:0]  rdat;
  } frame_t;

  typedef struct {
    logic [10:0] bits;
    int          len;
    bit          rd;
    logic [7:0]  rsp;
  } exp_t;

  frame_t     frm_q[$];
  exp_t       exp_q[$];
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;
  int         mon_err = 0;
  int         n_since_rst = 0;
  logic [7:0] ref_ram[256];
  logic [7:0] ref_addr;
  logic [7:0] sram[256];
  logic [7:0] saddr;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Pin-level slave: collects each SS_n-low frame, acts on it like the RAM wrapper, drives MISO.
  initial begin : slave_model
    int          n;
    int          hi;
    logic [10:0] bits;
    logic [7:0]  rb;
    frame_t      fr;
    n = 0;
    hi = 0;
    bits = '0;
    saddr = '0;
    bus_if.MISO = 1'b0;
    for (int i = 0; i < 256; i++) sram[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (bus_if.cmd_ready === 1'b1 && bus_if.busy === 1'b1) mon_err++;
      if (bus_if.SS_n === 1'b0) begin
        if (bus_if.busy !== 1'b1) mon_err++;
        n++;
        if (n <= 11) bits = {bits[9:0], bus_if.MOSI};
        else if (bus_if.MOSI !== 1'b0) mon_err++;
        if (n >= 14 && n <= 21 && bits[9:8] == 2'b11) begin
          rb = sram[saddr];
          bus_if.MISO = rb[3'(21 - n)];
        end else begin
          bus_if.MISO = 1'b0;
        end
      end else begin
        bus_if.MISO = 1'b0;
        if (bus_if.MOSI !== 1'b0) mon_err++;
        if (n > 0) begin
          if (n == 11 || n == 21) begin
            case (bits[9:8])
              2'b00, 2'b10: saddr = bits[7:0];
              2'b01:        sram[saddr] = bits[7:0];
              default:      ;
            endcase
          end
          fr.len = n;
          fr.bits = bits;
          fr.gap = hi;
          fr.rcnt = 0;
          fr.rdat = '0;
          frm_q.push_back(fr);
          n = 0;
          hi = 0;
          bits = '0;
        end
        hi++;
      end
      // A response pulse belongs to the frame that just ended.
      if (bus_if.rsp_valid === 1'b1) begin
        if (frm_q.size() == 0) begin
          mon_err++;
        end else begin
          fr = frm_q.pop_back();
          fr.rcnt++;
          fr.rdat = bus_if.rsp_data;
          frm_q.push_back(fr);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Command-level reference: what each accepted command should look like on the wire.
  function automatic void ref_push(input logic [1:0] op, input logic [7:0] d);
    exp_t e;
    e.bits = {op[1], op, d};
    e.rd   = (op == 2'b11);
    e.len  = e.rd ? 11 + int'(TA) + 8 : 11;
    e.rsp  = ref_ram[ref_addr];
    case (op)
      2'b00, 2'b10: ref_addr = d;
      2'b01:        ref_ram[ref_addr] = d;
      default:      ;
    endcase
    exp_q.push_back(e);
    n_since_rst++;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] d, input bit keep, input bit track);
    int w;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op = op;
    bus_if.cmd_data = d;
    w = 0;
    while (bus_if.cmd_ready !== 1'b1 && w < 100) begin
      step();
      w++;
    end
    chk("accept_in_time", (w < 100) ? 1 : 0, 1);
    @(posedge clk);
    if (track) ref_push(op, d);
    step();
    if (!keep) bus_if.cmd_valid = 1'b0;
    bus_if.cmd_op = 2'($urandom);
    bus_if.cmd_data = 8'($urandom);
  endtask

  task automatic drain();
    int     w;
    exp_t   e;
    frame_t f;
    w = 0;
    while (frm_q.size() < exp_q.size() && w < 2000) begin
      step();
      w++;
    end
    chk("frames_arrived", frm_q.size(), exp_q.size());
    repeat (3) step();
    while (exp_q.size() > 0 && frm_q.size() > 0) begin
      e = exp_q.pop_front();
      f = frm_q.pop_front();
      chk("frame_len", f.len, e.len);
      chk("frame_bits", f.bits, e.bits);
      chk("ss_gap", (f.gap >= int'(GAP)) ? 1 : 0, 1);
      chk("rsp_pulses", f.rcnt, e.rd ? 1 : 0);
      if (e.rd) chk("rsp_data", f.rdat, e.rsp);
    end
    exp_q.delete();
    frm_q.delete();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : main
    frame_t     f;
    logic [1:0] op;
    logic [7:0] d;

    rst_n = 1'b0;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_op = 2'b01;
    bus_if.cmd_data = 8'hFF;
    ref_addr = '0;
    for (int i = 0; i < 256; i++) ref_ram[i] = init_byte(i);

    // Reset held three clocks with a command offered.
    repeat (3) step();
    chk("rst_ss_n", bus_if.SS_n, 1);
    chk("rst_mosi", bus_if.MOSI, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_rsp_data", bus_if.rsp_data, 0);
    chk("rst_cmd_ready", bus_if.cmd_ready, 0);
    chk("rst_busy", bus_if.busy, 0);
    bus_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", bus_if.cmd_ready, 1);
    chk("post_rst_ss_n", bus_if.SS_n, 1);
    chk("no_frame_in_rst", frm_q.size(), 0);
    n_since_rst = 0;

    // Single wr-addr frame, then the ready returns after the gap.
    issue(2'b00, 8'hA5, 1'b0, 1'b1);
    drain();
    chk("ready_after_gap", bus_if.cmd_ready, 1);

    // Write, address, read back.
    issue(2'b01, 8'h3C, 1'b0, 1'b1);
    issue(2'b10, 8'hA5, 1'b0, 1'b1);
    issue(2'b11, 8'h00, 1'b0, 1'b1);
    drain();

    // Back-to-back with cmd_valid held high throughout.
    issue(2'b00, 8'h10, 1'b1, 1'b1);
    issue(2'b01, 8'h77, 1'b1, 1'b1);
    issue(2'b10, 8'h10, 1'b1, 1'b1);
    issue(2'b11, 8'($urandom), 1'b1, 1'b1);
    bus_if.cmd_valid = 1'b0;
    drain();

    // Random command mix over a small address window so reads hit earlier writes.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 6; k++) begin
        op = 2'($urandom_range(0, 3));
        d = (op[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        issue(op, d, 1'($urandom_range(0, 1)), 1'b1);
      end
      bus_if.cmd_valid = 1'b0;
      drain();
    end

    // Abort a wr-data frame during its 5th shift bit.
    issue(2'b00, 8'h20, 1'b0, 1'b1);
    drain();
    issue(2'b01, 8'h99, 1'b0, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("abort_ss_n", bus_if.SS_n, 1);
    chk("abort_mosi", bus_if.MOSI, 0);
    chk("abort_busy", bus_if.busy, 0);
    chk("abort_rsp_valid", bus_if.rsp_valid, 0);
    rst_n = 1'b1;
    n_since_rst = 0;
    repeat (4) step();
    chk("abort_frames", frm_q.size(), 1);
    if (frm_q.size() > 0) begin
      f = frm_q.pop_front();
      chk("abort_len", f.len, 6);
      chk("abort_bits", f.bits[5:0], 6'b001100);
      chk("abort_rsp", f.rcnt, 0);
    end
    frm_q.delete();
    // Address survives in the slave; the aborted write must not have landed.
    issue(2'b11, 8'h00, 1'b0, 1'b1);
    issue(2'b01, 8'h5E, 1'b0, 1'b1);
    issue(2'b11, 8'h00, 1'b0, 1'b1);
    drain();

`ifdef SPI_MASTER_FRAME_CNT_EN
    chk("frame_cnt", bus_if.frame_cnt, n_since_rst);
`endif
    chk("pin_protocol", mon_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
